// File: rtl/t03_pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : t03_pc_ras
// Brief    : RV32I program counter with trap redirect, misaligned-target
//            rejection and a circular return-address stack with mispredict
//            counting.
// Revision : 1.0 - initial release
// ============================================================================
module t03_pc_ras #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BASE_ADDRESS = '0,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              RAS_DEPTH    = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             freezePc,
    input  logic [2:0]       control,
    input  logic [XLEN-1:0]  offset,
    input  logic [XLEN-1:0]  ALUResult,
    input  logic [XLEN-1:0]  trapVector,
    output logic [XLEN-1:0]  currentPc,
    output logic [XLEN-1:0]  currentPc_base_address,
    output logic [XLEN-1:0]  toMemory,
    output logic             misaligned,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasMispredict,
    output logic [CNT_W-1:0] mispredictCount
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    localparam logic [2:0] c_MODE_JALR   = 3'b001;
    localparam logic [2:0] c_MODE_BRANCH = 3'b010;
    localparam logic [2:0] c_MODE_CALL   = 3'b011;
    localparam logic [2:0] c_MODE_RET    = 3'b100;
    localparam logic [2:0] c_MODE_TRAP   = 3'b101;

    localparam logic [XLEN-1:0]     c_FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0]     c_ONE   = XLEN'(1);
    localparam logic [CNT_BITS-1:0] c_DEPTH = CNT_BITS'(RAS_DEPTH);

    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]    r_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                r_misaligned;
    logic                r_mispredict;
    logic [CNT_W-1:0]    r_mis_cnt;

    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_alu_aligned;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_checked;
    logic             w_reject;
    logic             w_push;
    logic             w_ret;
    logic             w_bad_ret;
    logic [PTR_W-1:0] w_top_idx;

    assign w_seq_pc      = r_pc + c_FOUR;
    assign w_alu_aligned = ALUResult & ~c_ONE;

    always_comb begin
        w_target  = w_seq_pc;
        w_checked = 1'b0;
        case (control)
            c_MODE_JALR, c_MODE_RET: begin
                w_target  = w_alu_aligned;
                w_checked = 1'b1;
            end
            c_MODE_BRANCH, c_MODE_CALL: begin
                w_target  = r_pc + offset;
                w_checked = 1'b1;
            end
            c_MODE_TRAP: w_target = trapVector;
            default:     w_target = w_seq_pc;
        endcase
    end

    // TRAP and SEQ never set w_checked, so they can never be rejected.
    assign w_reject  = w_checked && (w_target[1:0] != 2'b00);
    assign w_next_pc = w_reject ? w_seq_pc : w_target;

    assign w_push    = !freezePc && (control == c_MODE_CALL) && !w_reject;
    assign w_ret     = !freezePc && (control == c_MODE_RET) && !w_reject;
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_bad_ret = w_ret && ((r_count == '0) || (r_ras[w_top_idx] != w_alu_aligned));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc         <= RESET_PC;
            r_ptr        <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
            r_mispredict <= 1'b0;
            r_mis_cnt    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            r_misaligned <= !freezePc && w_reject;
            r_mispredict <= w_bad_ret;
            if (!freezePc) begin
                r_pc <= w_next_pc;
            end
            if (w_push) begin
                r_ras[r_ptr] <= w_seq_pc;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (r_count != c_DEPTH) begin
                    r_count <= r_count + CNT_BITS'(1);
                end
            end else if (w_ret && (r_count != '0)) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_BITS'(1);
            end
            if (w_bad_ret && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign currentPc              = r_pc;
    assign currentPc_base_address = r_pc + BASE_ADDRESS;
    assign toMemory               = w_next_pc + BASE_ADDRESS;
    assign misaligned             = r_misaligned;
    assign rasEmpty               = (r_count == '0);
    assign rasFull                = (r_count == c_DEPTH);
    assign rasMispredict          = r_mispredict;
    assign mispredictCount        = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_t03_pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_t03_pc_ras
// Brief    : Directed self-checking bench for t03_pc_ras.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t03_pc_ras;

    localparam logic [2:0] c_SEQ = 3'b000, c_JALR = 3'b001, c_BR = 3'b010,
                           c_CALL = 3'b011, c_RET = 3'b100, c_TRAP = 3'b101;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        freezePc = 1'b0;
    logic [2:0]  control = c_SEQ;
    logic [31:0] offset = '0;
    logic [31:0] ALUResult = '0;
    logic [31:0] trapVector = '0;
    logic [31:0] currentPc, currentPc_base_address, toMemory;
    logic        misaligned, rasEmpty, rasFull, rasMispredict;
    logic [1:0]  mispredictCount;

    int r_errors = 0;
    int r_checks = 0;

    t03_pc_ras #(
        .XLEN(32), .BASE_ADDRESS(32'h3300_0000), .RESET_PC(32'h0000_0100),
        .RAS_DEPTH(4), .CNT_W(2)
    ) u_dut (
        .clk(clk), .nrst(nrst), .freezePc(freezePc), .control(control),
        .offset(offset), .ALUResult(ALUResult), .trapVector(trapVector),
        .currentPc(currentPc), .currentPc_base_address(currentPc_base_address),
        .toMemory(toMemory), .misaligned(misaligned), .rasEmpty(rasEmpty),
        .rasFull(rasFull), .rasMispredict(rasMispredict),
        .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        control  = c_SEQ;
        freezePc = 1'b0;
        nrst     = 1'b0;
        #1;
        @(negedge clk);
        nrst = 1'b1;
        #1;
    endtask

    task automatic go(input logic [2:0] mode, input logic [31:0] off, input logic [31:0] alu);
        control   = mode;
        offset    = off;
        ALUResult = alu;
        tick();
    endtask

    task automatic trap_to(input logic [31:0] vec);
        trapVector = vec;
        go(c_TRAP, 32'h0, 32'h0);
    endtask

    logic [31:0] w_ret_addr [5];

    initial begin
        // Reset and sequential fetch
        do_reset();
        chk("rst_pc", currentPc, 32'h0000_0100);
        chk("rst_empty", {31'b0, rasEmpty}, 32'h1);
        chk("rst_full", {31'b0, rasFull}, 32'h0);
        chk("rst_cnt", {30'b0, mispredictCount}, 32'h0);
        chk("rst_tomem", toMemory, 32'h3300_0104);
        go(c_SEQ, 0, 0);
        chk("seq1", currentPc, 32'h0000_0104);
        go(c_SEQ, 0, 0);
        chk("seq2", currentPc, 32'h0000_0108);
        go(c_SEQ, 0, 0);
        chk("seq3", currentPc, 32'h0000_010C);
        chk("seq3_base", currentPc_base_address, 32'h3300_010C);
        chk("seq3_tomem", toMemory, 32'h3300_0110);

        // Nested call / return
        trap_to(32'h0000_0200);
        chk("trap_200", currentPc, 32'h0000_0200);
        go(c_CALL, 32'h100, 0);
        chk("call1_pc", currentPc, 32'h0000_0300);
        chk("call1_nempty", {31'b0, rasEmpty}, 32'h0);
        go(c_CALL, 32'h40, 0);
        chk("call2_pc", currentPc, 32'h0000_0340);
        go(c_RET, 0, 32'h0000_0304);
        chk("ret1_pc", currentPc, 32'h0000_0304);
        chk("ret1_mp", {31'b0, rasMispredict}, 32'h0);
        go(c_RET, 0, 32'h0000_0204);
        chk("ret2_pc", currentPc, 32'h0000_0204);
        chk("ret2_mp", {31'b0, rasMispredict}, 32'h0);
        chk("ret2_empty", {31'b0, rasEmpty}, 32'h1);
        chk("nest_cnt", {30'b0, mispredictCount}, 32'h0);

        // Overflow: five calls into a four-deep stack
        do_reset();
        trap_to(32'h0000_1000);
        for (int i = 0; i < 5; i++) begin
            w_ret_addr[i] = 32'h0000_1004 + 32'h100 * i;
            go(c_CALL, 32'h100, 0);
        end
        chk("ovf_pc", currentPc, 32'h0000_1500);
        chk("ovf_full", {31'b0, rasFull}, 32'h1);
        for (int i = 4; i >= 1; i--) begin
            go(c_RET, 0, w_ret_addr[i]);
            chk("ovf_ret_mp", {31'b0, rasMispredict}, 32'h0);
            chk("ovf_ret_pc", currentPc, w_ret_addr[i]);
        end
        chk("ovf_empty", {31'b0, rasEmpty}, 32'h1);
        go(c_RET, 0, w_ret_addr[0]);
        chk("ovf_a1_mp", {31'b0, rasMispredict}, 32'h1);
        chk("ovf_a1_cnt", {30'b0, mispredictCount}, 32'h1);
        chk("ovf_a1_pc", currentPc, 32'h0000_1004);
        go(c_SEQ, 0, 0);
        chk("ovf_pulse_end", {31'b0, rasMispredict}, 32'h0);

        // Misaligned targets
        trap_to(32'h0000_0400);
        go(c_JALR, 0, 32'h0000_0402);
        chk("mis_jalr_pc", currentPc, 32'h0000_0404);
        chk("mis_jalr_flag", {31'b0, misaligned}, 32'h1);
        go(c_BR, 32'h6, 0);
        chk("mis_br_pc", currentPc, 32'h0000_0408);
        chk("mis_br_flag", {31'b0, misaligned}, 32'h1);
        go(c_CALL, 32'h2, 0);
        chk("mis_call_pc", currentPc, 32'h0000_040C);
        chk("mis_call_empty", {31'b0, rasEmpty}, 32'h1);
        go(c_SEQ, 0, 0);
        chk("mis_clear", {31'b0, misaligned}, 32'h0);
        trap_to(32'h0000_0002);
        chk("trap2_pc", currentPc, 32'h0000_0002);
        chk("trap2_flag", {31'b0, misaligned}, 32'h0);

        // Freeze during a CALL
        do_reset();
        freezePc = 1'b1;
        control  = c_CALL;
        offset   = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_pc", currentPc, 32'h0000_0100);
            chk("frz_empty", {31'b0, rasEmpty}, 32'h1);
            chk("frz_tomem", toMemory, 32'h3300_0120);
        end
        freezePc = 1'b0;
        tick();
        chk("frz_rel_pc", currentPc, 32'h0000_0120);
        go(c_RET, 0, 32'h0000_0104);
        chk("frz_ret_mp", {31'b0, rasMispredict}, 32'h0);
        chk("frz_single_push", {31'b0, rasEmpty}, 32'h1);

        // PC wrap
        trap_to(32'hFFFF_FFFC);
        chk("wrap_base", currentPc_base_address, 32'h32FF_FFFC);
        go(c_SEQ, 0, 0);
        chk("wrap_pc", currentPc, 32'h0000_0000);
        chk("wrap_tomem", toMemory, 32'h3300_0004);

        // Counter saturation then asynchronous reset mid-pulse
        do_reset();
        for (int i = 0; i < 5; i++) begin
            go(c_RET, 0, 32'h0000_0200);
            chk("sat_mp", {31'b0, rasMispredict}, 32'h1);
        end
        chk("sat_cnt", {30'b0, mispredictCount}, 32'h3);
        go(c_CALL, 32'h8, 0);
        chk("pre_rst_nempty", {31'b0, rasEmpty}, 32'h0);
        go(c_RET, 0, 32'h0000_0300);
        chk("pre_rst_mp", {31'b0, rasMispredict}, 32'h1);
        nrst = 1'b0;
        #1;
        chk("arst_pc", currentPc, 32'h0000_0100);
        chk("arst_mp", {31'b0, rasMispredict}, 32'h0);
        chk("arst_cnt", {30'b0, mispredictCount}, 32'h0);
        chk("arst_empty", {31'b0, rasEmpty}, 32'h1);
        chk("arst_mis", {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        nrst = 1'b1;

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
